// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with single-cycle logic/arith/shift ops and an
// optional multi-cycle shift-add multiplier.
//
// Build option: define SEQ_ALU_MUL_EN to build the multi-cycle MUL (SELECT=7).
// Without it there is no MUL state or multiplier; SELECT=7 completes in one
// cycle with RESULT=0, ZERO=1, CARRY=0, and BUSY is tied low.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset (priority over start)
//   start   in   request strobe, sampled only while busy=0
//   data1   in   operand A
//   data2   in   operand B / shift amount
//   select  in   opcode: 0 FWD(B) 1 ADD 2 AND 3 OR 4 SUB 5 SLL 6 SRL 7 MUL
//   result  out  registered result, held until the next completion
//   zero    out  registered, result of the latest completion is zero
//   carry   out  registered, ADD carry-out / SUB borrow, 0 otherwise
//   busy    out  multi-cycle operation in progress
//   done    out  one-cycle completion pulse
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_FWD = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SUB = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH[WIDTH-1:0];

    op_t              op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    logic [WIDTH-1:0] result_nxt;
    logic             zero_nxt;
    logic             carry_nxt;
    logic             done_nxt;

    assign op = op_t'(select);

    // Single-cycle datapath, evaluated on the live inputs at the START edge.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned -- otherwise a latch is inferred.
    always_comb begin
        sum       = {1'b0, data1} + {1'b0, data2};
        diff      = {1'b0, data1} - {1'b0, data2};
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (op)
            OP_FWD: alu_res = data2;
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_AND: alu_res = data1 & data2;
            OP_OR:  alu_res = data1 | data2;
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];     // borrow: set when A < B
            end
            // Shift amounts of WIDTH or more flush every bit out.
            OP_SLL: alu_res = (data2 >= WIDTH_VAL) ? '0 : (data1 << data2);
            OP_SRL: alu_res = (data2 >= WIDTH_VAL) ? '0 : (data1 >> data2);
            OP_MUL: alu_res = '0;            // single-cycle stand-in when MUL is not built
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int                CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    step_nxt;
    logic [WIDTH-1:0] acc_step;

    // Only the low WIDTH bits of the product are kept, so the accumulator and
    // the left-shifting multiplicand can both stay WIDTH bits wide.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        zero_nxt   = zero;
        carry_nxt  = carry;
        done_nxt   = 1'b0;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        step_nxt   = step;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_nxt  = MUL;
                        mcand_nxt  = data1;
                        mplier_nxt = data2;
                        acc_nxt    = '0;
                        step_nxt   = '0;
                    end else begin
                        result_nxt = alu_res;
                        zero_nxt   = (alu_res == '0);
                        carry_nxt  = alu_carry;
                        done_nxt   = 1'b1;
                    end
                end
            end
            MUL: begin
                // One shift-add step per cycle; start is ignored here.
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                step_nxt   = step + 1'b1;
                if (step == LAST_STEP) begin
                    state_nxt  = IDLE;
                    result_nxt = acc_step;
                    zero_nxt   = (acc_step == '0);
                    carry_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the multiplier working registers are deliberately not reset; they
    // are always loaded at the START edge before being read.
    always_ff @(posedge clk) begin
        mcand  <= mcand_nxt;
        mplier <= mplier_nxt;
        acc    <= acc_nxt;
        step   <= step_nxt;
    end

    assign busy = (state == MUL);
`else
    always_comb begin
        result_nxt = result;
        zero_nxt   = zero;
        carry_nxt  = carry;
        done_nxt   = 1'b0;
        if (start) begin
            result_nxt = alu_res;
            zero_nxt   = (alu_res == '0);
            carry_nxt  = alu_carry;
            done_nxt   = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    // Architectural outputs: change only on a completion or on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            done   <= 1'b0;
        end else begin
            result <= result_nxt;
            zero   <= zero_nxt;
            carry  <= carry_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed self-checking bench for seq_alu (WIDTH=8).
// Expected completions are pushed to a scoreboard queue when a request is
// driven and popped when the DUT raises done. Compile with or without
// SEQ_ALU_MUL_EN to match the RTL build.
module tb_seq_alu;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       select;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_seen = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data1  (data1),
        .data2  (data2),
        .select (select),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1) busy_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the START edge. Waits (bounded) for done, checking busy
    // on every waiting cycle, then pops the scoreboard and compares.
    // With disturb set, inputs are zeroed and start is toggled while busy.
    task automatic wait_done(input string tag, input bit disturb);
        exp_t e;
        int   n = 0;
        chk($sformatf("%s sb_nonempty", tag), 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        while (done !== 1'b1 && n < 40) begin
            chk($sformatf("%s busy_c%0d", tag, n), 32'(busy), 32'd1);
            if (disturb) begin
                data1  = '0;
                data2  = '0;
                select = 3'd1;
                start  = n[0];
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk($sformatf("%s latency", tag), 32'(n), 32'(e.lat));
        chk($sformatf("%s done", tag), 32'(done), 32'd1);
        chk($sformatf("%s result", tag), 32'(result), 32'(e.res));
        chk($sformatf("%s zero", tag), 32'(zero), 32'(e.z));
        chk($sformatf("%s carry", tag), 32'(carry), 32'(e.c));
        chk($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
    endtask

    task automatic issue(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] sel, input logic [WIDTH-1:0] er, input logic ez,
                         input logic ec, input int lat, input bit disturb);
        data1  = a;
        data2  = b;
        select = sel;
        start  = 1'b1;
        sb.push_back('{er, ez, ec, lat});
        tick();
        start = 1'b0;
        wait_done(tag, disturb);
    endtask

    initial begin
        int done_hits;
        reset  = 1'b1;
        start  = 1'b0;
        data1  = '0;
        data2  = '0;
        select = '0;
        tick();
        tick();
        chk("rst result", 32'(result), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst carry", 32'(carry), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst done", 32'(done), 32'd0);

        // Single-cycle ops, issued back to back (start during done is accepted).
        issue("add",    8'd28,  8'd38,  3'd1, 8'd66,  1'b0, 1'b0, 0, 1'b0);
        issue("and",    8'd28,  8'd38,  3'd2, 8'd4,   1'b0, 1'b0, 0, 1'b0);
        issue("or",     8'd28,  8'd38,  3'd3, 8'd62,  1'b0, 1'b0, 0, 1'b0);
        issue("sub",    8'd28,  8'd38,  3'd4, 8'd246, 1'b0, 1'b1, 0, 1'b0);
        issue("sll8",   8'd1,   8'd8,   3'd5, 8'd0,   1'b1, 1'b0, 0, 1'b0);
        issue("fwd",    8'd28,  8'd38,  3'd0, 8'd38,  1'b0, 1'b0, 0, 1'b0);
        issue("addc",   8'd200, 8'd100, 3'd1, 8'd44,  1'b0, 1'b1, 0, 1'b0);
        issue("subeq",  8'd5,   8'd5,   3'd4, 8'd0,   1'b1, 1'b0, 0, 1'b0);
        issue("srl7",   8'd128, 8'd7,   3'd6, 8'd1,   1'b0, 1'b0, 0, 1'b0);
        issue("sll2",   8'd3,   8'd2,   3'd5, 8'd12,  1'b0, 1'b0, 0, 1'b0);
        issue("srlbig", 8'd255, 8'd200, 3'd6, 8'd0,   1'b1, 1'b0, 0, 1'b0);
        issue("addwrap",8'd255, 8'd1,   3'd1, 8'd0,   1'b1, 1'b1, 0, 1'b0);

        // Idle: inputs change without start; done drops, outputs hold.
        tick();
        chk("pulse done_low", 32'(done), 32'd0);
        data1  = 8'd9;
        data2  = 8'd9;
        select = 3'd0;
        tick();
        tick();
        chk("idle result_hold", 32'(result), 32'd0);
        chk("idle carry_hold", 32'(carry), 32'd1);
        chk("idle done", 32'(done), 32'd0);

`ifdef SEQ_ALU_MUL_EN
        issue("mul255", 8'd255, 8'd255, 3'd7, 8'd1,  1'b0, 1'b0, WIDTH, 1'b0);
        issue("mulz",   8'd16,  8'd16,  3'd7, 8'd0,  1'b1, 1'b0, WIDTH, 1'b0);
        // 28*38 = 1064 -> low byte 40; inputs zeroed and start pulsed mid-op.
        issue("mul",    8'd28,  8'd38,  3'd7, 8'd40, 1'b0, 1'b0, WIDTH, 1'b1);
        tick();
        chk("mul done_once", 32'(done), 32'd0);
        chk("mul idle_busy", 32'(busy), 32'd0);
        chk("mul result_hold", 32'(result), 32'd40);

        // Reset in the 4th busy cycle of a MUL, with a start on the same edge.
        data1  = 8'd28;
        data2  = 8'd38;
        select = 3'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("abort busy_c1", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        chk("abort busy_c4", 32'(busy), 32'd1);
        reset  = 1'b1;
        start  = 1'b1;
        select = 3'd1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort zero", 32'(zero), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        done_hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_hits++;
        end
        chk("abort no_done", 32'(done_hits), 32'd0);
`else
        issue("sel7",  8'd28, 8'd38, 3'd7, 8'd0, 1'b1, 1'b0, 0, 1'b0);
        tick();
        chk("sel7 done_low", 32'(done), 32'd0);
        chk("busy never", 32'(busy_seen), 32'd0);
`endif

        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; legal range 4..32.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request strobe; sampled only while BUSY=0.
REQ-005 DATA1  input  WIDTH  operand A.
REQ-006 DATA2  input  WIDTH  operand B, and the shift amount for shift ops.
REQ-007 SELECT  input  3  opcode: 0 FWD(B), 1 ADD, 2 AND, 3 OR, 4 SUB(A-B), 5 SLL(A<<B), 6 SRL(A>>B), 7 MUL.
REQ-008 RESULT  output  WIDTH  registered result; holds until the next completion.
REQ-009 ZERO  output  1  registered; 1 when the latest completed RESULT==0.
REQ-010 CARRY  output  1  registered; ADD carry-out or SUB borrow (A<B), 0 for all other ops.
REQ-011 BUSY  output  1  high while a multi-cycle op is in progress.
REQ-012 DONE  output  1  one-cycle pulse marking a completion.

Function
REQ-013 States are IDLE and MUL; BUSY=1 exactly when in MUL.
REQ-014 In IDLE, a rising edge with START=1 latches DATA1, DATA2 and SELECT; later input changes do not affect that operation.
REQ-015 Ops 0-6 write RESULT, ZERO and CARRY on the START edge, assert DONE for the following cycle, and remain in IDLE (latency 1).
REQ-016 ADD/SUB use modulo 2^WIDTH arithmetic with CARRY taken from the (WIDTH+1)-bit sum/difference.
REQ-017 SLL/SRL are logical shifts (zero fill); any shift amount >= WIDTH gives RESULT=0.
REQ-018 MUL enters the MUL state and performs one shift-add step per cycle for WIDTH cycles.
REQ-019 MUL writes RESULT (low WIDTH bits of the product) on the WIDTH-th edge after the START edge, sets BUSY=0 and asserts DONE for the following cycle.
REQ-020 START while BUSY=1 is ignored, with no queuing and no effect on the current operation.
REQ-021 START in the cycle DONE=1 is accepted, because the block is already in IDLE.
REQ-022 DONE is never high for two consecutive cycles unless a new operation was accepted in the DONE cycle.
REQ-023 RESULT, ZERO and CARRY change only on a completion or on reset.

Reset
REQ-024 An edge with RESET=1 forces IDLE, RESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0; RESET takes priority over START.
REQ-025 Reset during MUL aborts the operation with no DONE pulse, and any START on the same edge is discarded.

Configuration
REQ-026 Macro SEQ_ALU_MUL_EN defined: SELECT=7 performs the multi-cycle MUL of REQ-018/019.
REQ-027 Macro SEQ_ALU_MUL_EN undefined:
- no MUL state or multiplier datapath is built, and BUSY is tied to 0;
- SELECT=7 completes in 1 cycle with RESULT=0, ZERO=1, CARRY=0 and DONE pulsed.

Verification
REQ-028 Bench (WIDTH=8) shall cover: DATA1=28, DATA2=38, SELECT=1, START pulse -> next cycle DONE=1, RESULT=66, CARRY=0, ZERO=0.
REQ-029 Bench shall cover: 28/38 with SELECT=2 -> RESULT=4; with SELECT=3 -> RESULT=62; with SELECT=4 -> RESULT=246, CARRY=1; each with a 1-cycle DONE.
REQ-030 Bench shall cover: DATA1=1, DATA2=8, SELECT=5 -> RESULT=0, ZERO=1.
REQ-031 Bench shall cover, with SEQ_ALU_MUL_EN defined: 28*38 (SELECT=7) -> BUSY=1 for 8 cycles, then DONE=1, RESULT=40.
- Inputs changed to 0 mid-operation do not alter RESULT.
- START pulses while BUSY=1 are ignored.
REQ-032 Bench shall cover: RESET=1 on the 4th cycle of a MUL -> next cycle BUSY=0, RESULT=0, and no DONE afterwards.
REQ-033 Bench shall cover, with SEQ_ALU_MUL_EN undefined: SELECT=7 -> DONE after 1 cycle, RESULT=0, ZERO=1, BUSY never 1.
